// File: rtl/hs32_mem_pkg.sv
// Shared types and constants for the hs32 memory-port arbitration logic.
package hs32_mem_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic PORT_I   = 1'b0;
  localparam logic PORT_D   = 1'b1;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on contention the requester that
// was not served last wins.
module rr_pick2
  import hs32_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Select the winning requester index
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = PORT_I;
    case (req)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_idx   = PORT_I;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_idx   = PORT_D;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_idx   = (last == PORT_I) ? PORT_D : PORT_I;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_idx   = PORT_I;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory-interface port between instruction fetch (port 0) and
// load/store (port 1); the granted request is latched and replayed downstream.
module mem_arbiter
  import hs32_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_dtw,
  output logic [DW-1:0] i_dtr,
  input  logic          i_rw,
  input  logic          d_valid,
  output logic          d_ready,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_dtw,
  output logic [DW-1:0] d_dtr,
  input  logic          d_rw,
  output logic          valid,
  input  logic          ready,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] dtw,
  input  logic [DW-1:0] dtr,
  output logic          rw
);

  arb_state_t    state_r, state_s;
  logic          grant_r, grant_s;
  logic          last_r, last_s;
  logic          valid_r, valid_s;
  logic [AW-1:0] addr_r, addr_s;
  logic [DW-1:0] dtw_r, dtw_s;
  logic          rw_r, rw_s;
  logic          gnt_valid_s;
  logic          gnt_idx_s;
  logic          done_s;

  rr_pick2 u_pick (
    .req       ({d_valid, i_valid}),
    .last      (last_r),
    .gnt_valid (gnt_valid_s),
    .gnt_idx   (gnt_idx_s)
  );

  // State and latched downstream request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      grant_r <= PORT_I;
      last_r  <= PORT_D;
      valid_r <= 1'b0;
      addr_r  <= {AW{1'b0}};
      dtw_r   <= {DW{1'b0}};
      rw_r    <= RW_READ;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      last_r  <= last_s;
      valid_r <= valid_s;
      addr_r  <= addr_s;
      dtw_r   <= dtw_s;
      rw_r    <= rw_s;
    end
  end

  // Next-state: grant in IDLE, wait for downstream completion in BUSY
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    last_s  = last_r;
    valid_s = valid_r;
    addr_s  = addr_r;
    dtw_s   = dtw_r;
    rw_s    = rw_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (gnt_valid_s) begin
          grant_s = gnt_idx_s;
          valid_s = 1'b1;
          state_s = BUSY;
          if (gnt_idx_s == PORT_D) begin
            addr_s = d_addr;
            dtw_s  = d_dtw;
            rw_s   = d_rw;
          end else begin
            addr_s = i_addr;
            dtw_s  = i_dtw;
            rw_s   = i_rw;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (ready) begin
          done_s  = 1'b1;
          last_s  = grant_r;
          valid_s = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  // Completion and read data are routed only to the granted requester
  always_comb begin
    i_ready = 1'b0;
    d_ready = 1'b0;
    i_dtr   = {DW{1'b0}};
    d_dtr   = {DW{1'b0}};
    if (state_r == BUSY) begin
      if (grant_r == PORT_D) begin
        d_ready = done_s;
        d_dtr   = dtr;
      end else begin
        i_ready = done_s;
        i_dtr   = dtr;
      end
    end else begin
      i_ready = 1'b0;
      d_ready = 1'b0;
    end
  end

  assign valid = valid_r;
  assign addr  = addr_r;
  assign dtw   = dtw_r;
  assign rw    = rw_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester drivers, a downstream responder
// model and a completion monitor checking against expected grant order.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_valid, i_ready, i_rw;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_dtw, i_dtr;
  logic          d_valid, d_ready, d_rw;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_dtw, d_dtr;
  logic          valid, ready, rw;
  logic [AW-1:0] addr;
  logic [DW-1:0] dtw, dtr;

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] dtw;
    logic        rw;
    logic [31:0] dtr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] dtw;
    logic        rw;
  } req_t;

  exp_t expq[$];
  req_t iq[$];
  req_t dq[$];

  int   checks = 0;
  int   errors = 0;
  bit   i_busy = 1'b0, d_busy = 1'b0, i_done = 1'b0, d_done = 1'b0;
  int   lat = 0;
  int   cnt = 0;
  logic [31:0] rdata = 32'h0;
  logic rdy = 1'b0;
  logic spur = 1'b0;

  logic        prev_done = 1'b0, prev_valid = 1'b0, prev_rw = 1'b0;
  logic [31:0] prev_addr = 32'h0, prev_dtw = 32'h0;
  exp_t        mon_e;

  assign ready = rdy | spur;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_dtw(i_dtw),
    .i_dtr(i_dtr), .i_rw(i_rw),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_dtw(d_dtw),
    .d_dtr(d_dtr), .d_rw(d_rw),
    .valid(valid), .ready(ready), .addr(addr), .dtw(dtw), .dtr(dtr), .rw(rw)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (expq.size() == 0 && iq.size() == 0 && dq.size() == 0 && !i_busy && !d_busy)
        return;
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: got %0d pending expected 0", expq.size());
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (valid === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL valid_timeout: got %b expected 1", valid);
  endtask

  function automatic exp_t mk(input logic p, input logic [31:0] a, input logic [31:0] w,
                              input logic r, input logic [31:0] d);
    exp_t e;
    e.port = p; e.addr = a; e.dtw = w; e.rw = r; e.dtr = d;
    return e;
  endfunction

  function automatic req_t mkr(input logic [31:0] a, input logic [31:0] w, input logic r);
    req_t q;
    q.addr = a; q.dtw = w; q.rw = r;
    return q;
  endfunction

  // Port 0 requester: holds its request until its ready has been seen
  initial begin
    req_t q;
    i_valid = 1'b0; i_addr = 32'h0; i_dtw = 32'h0; i_rw = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (i_busy && i_done) begin
        i_busy = 1'b0; i_done = 1'b0; i_valid = 1'b0;
      end
      if (!i_busy && iq.size() != 0) begin
        q = iq.pop_front();
        i_valid = 1'b1; i_addr = q.addr; i_dtw = q.dtw; i_rw = q.rw; i_busy = 1'b1;
      end
    end
  end

  // Port 1 requester
  initial begin
    req_t q;
    d_valid = 1'b0; d_addr = 32'h0; d_dtw = 32'h0; d_rw = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (d_busy && d_done) begin
        d_busy = 1'b0; d_done = 1'b0; d_valid = 1'b0;
      end
      if (!d_busy && dq.size() != 0) begin
        q = dq.pop_front();
        d_valid = 1'b1; d_addr = q.addr; d_dtw = q.dtw; d_rw = q.rw; d_busy = 1'b1;
      end
    end
  end

  // Downstream responder: ready after lat waiting cycles, one-cycle pulse
  initial begin
    dtr = 32'h0;
    forever begin
      @(posedge clk); #2;
      if (reset) begin
        rdy = 1'b0; cnt = 0; dtr = 32'h0;
      end else if (rdy) begin
        rdy = 1'b0; cnt = 0; dtr = 32'h0;
      end else if (valid) begin
        if (cnt >= lat) begin
          rdy = 1'b1; dtr = rdata;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: completions against the scoreboard, plus hold and gap rules
  initial begin
    forever begin
      @(negedge clk);
      if (prev_done) chk("gap_valid_low", {63'd0, valid}, 64'd0);
      if (valid && prev_valid && !prev_done) begin
        chk("hold_addr", {32'd0, addr}, {32'd0, prev_addr});
        chk("hold_dtw", {32'd0, dtw}, {32'd0, prev_dtw});
        chk("hold_rw", {63'd0, rw}, {63'd0, prev_rw});
      end
      if (i_ready || d_ready) begin
        chk("single_ready", {63'd0, i_ready & d_ready}, 64'd0);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got i_ready=%b d_ready=%b expected none", i_ready, d_ready);
        end else begin
          mon_e = expq.pop_front();
          chk("grant_port", {63'd0, d_ready}, {63'd0, mon_e.port});
          chk("ds_addr", {32'd0, addr}, {32'd0, mon_e.addr});
          chk("ds_dtw", {32'd0, dtw}, {32'd0, mon_e.dtw});
          chk("ds_rw", {63'd0, rw}, {63'd0, mon_e.rw});
          if (d_ready) begin
            chk("d_dtr", {32'd0, d_dtr}, {32'd0, mon_e.dtr});
            chk("i_dtr_zero", {32'd0, i_dtr}, 64'd0);
          end else begin
            chk("i_dtr", {32'd0, i_dtr}, {32'd0, mon_e.dtr});
            chk("d_dtr_zero", {32'd0, d_dtr}, 64'd0);
          end
        end
        if (i_ready) i_done = 1'b1;
        if (d_ready) d_done = 1'b1;
      end
      prev_done  = i_ready | d_ready;
      prev_valid = valid;
      prev_addr  = addr;
      prev_dtw   = dtw;
      prev_rw    = rw;
    end
  end

  // Directed stimulus
  initial begin
    reset = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_i_ready", {63'd0, i_ready}, 64'd0);
    chk("rst_d_ready", {63'd0, d_ready}, 64'd0);
    chk("rst_i_dtr", {32'd0, i_dtr}, 64'd0);
    chk("rst_d_dtr", {32'd0, d_dtr}, 64'd0);
    chk("rst_valid", {63'd0, valid}, 64'd0);
    chk("rst_addr", {32'd0, addr}, 64'd0);
    chk("rst_dtw", {32'd0, dtw}, 64'd0);
    chk("rst_rw", {63'd0, rw}, 64'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    @(negedge clk);

    // Contention straight after reset: port 0 first
    lat = 1; rdata = 32'h5A5A_5A5A;
    expq.push_back(mk(1'b0, 32'h0000_0300, 32'h0000_0000, 1'b0, 32'h5A5A_5A5A));
    expq.push_back(mk(1'b1, 32'h0000_0200, 32'h1234_5678, 1'b1, 32'h5A5A_5A5A));
    iq.push_back(mkr(32'h0000_0300, 32'h0000_0000, 1'b0));
    dq.push_back(mkr(32'h0000_0200, 32'h1234_5678, 1'b1));
    wait_idle();

    // Single read with request latency check
    lat = 3; rdata = 32'hDEAD_BEEF;
    expq.push_back(mk(1'b0, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF));
    iq.push_back(mkr(32'h0000_0100, 32'h0000_0000, 1'b0));
    @(negedge clk);
    chk("req_latency_pre", {63'd0, valid}, 64'd0);
    @(negedge clk);
    chk("req_latency_valid", {63'd0, valid}, 64'd1);
    chk("req_latency_addr", {32'd0, addr}, 64'h100);
    wait_idle();

    // Stability: port 1 changes its address mid-BUSY
    lat = 4; rdata = 32'h0BAD_F00D;
    expq.push_back(mk(1'b1, 32'h0000_0040, 32'h0000_0000, 1'b0, 32'h0BAD_F00D));
    dq.push_back(mkr(32'h0000_0040, 32'h0000_0000, 1'b0));
    wait_valid();
    @(posedge clk); #3;
    d_addr = 32'h0000_0080;
    @(negedge clk);
    chk("stable_addr", {32'd0, addr}, 64'h40);
    wait_idle();

    // Fairness: both ports continuously valid, ready on every BUSY cycle
    lat = 0; rdata = 32'h0F0F_0F0F;
    for (int k = 0; k < 4; k++) begin
      expq.push_back(mk(1'b0, 32'h0000_1000 + 32'(k * 4), 32'h1111_0000 + 32'(k), 1'b1, 32'h0F0F_0F0F));
      expq.push_back(mk(1'b1, 32'h0000_2000 + 32'(k * 4), 32'h2222_0000 + 32'(k), 1'b0, 32'h0F0F_0F0F));
      iq.push_back(mkr(32'h0000_1000 + 32'(k * 4), 32'h1111_0000 + 32'(k), 1'b1));
      dq.push_back(mkr(32'h0000_2000 + 32'(k * 4), 32'h2222_0000 + 32'(k), 1'b0));
    end
    wait_idle();

    // Spurious downstream ready in IDLE
    @(posedge clk); #3;
    spur = 1'b1;
    @(negedge clk);
    chk("spur_i_ready", {63'd0, i_ready}, 64'd0);
    chk("spur_d_ready", {63'd0, d_ready}, 64'd0);
    chk("spur_valid", {63'd0, valid}, 64'd0);
    @(posedge clk); #3;
    spur = 1'b0;
    @(negedge clk);
    chk("spur_valid_after", {63'd0, valid}, 64'd0);

    // Port 0 alone completes, leaving last pointing at port 0
    lat = 1; rdata = 32'h0000_0500;
    expq.push_back(mk(1'b0, 32'h0000_0500, 32'h0000_0000, 1'b0, 32'h0000_0500));
    iq.push_back(mkr(32'h0000_0500, 32'h0000_0000, 1'b0));
    wait_idle();

    // Reset mid-BUSY: transaction aborted, no requester ready
    lat = 10;
    iq.push_back(mkr(32'h0000_0600, 32'hFFFF_FFFF, 1'b1));
    wait_valid();
    @(posedge clk); #3;
    reset = 1'b1; i_valid = 1'b0; i_busy = 1'b0; i_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_valid", {63'd0, valid}, 64'd0);
    chk("midrst_addr", {32'd0, addr}, 64'd0);
    chk("midrst_dtw", {32'd0, dtw}, 64'd0);
    chk("midrst_rw", {63'd0, rw}, 64'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    @(negedge clk);

    // First contention after reset goes to port 0 again
    lat = 0; rdata = 32'h0000_0077;
    expq.push_back(mk(1'b0, 32'h0000_0700, 32'h0000_0000, 1'b0, 32'h0000_0077));
    expq.push_back(mk(1'b1, 32'h0000_0800, 32'hA5A5_A5A5, 1'b1, 32'h0000_0077));
    iq.push_back(mkr(32'h0000_0700, 32'h0000_0000, 1'b0));
    dq.push_back(mkr(32'h0000_0800, 32'hA5A5_A5A5, 1'b1));
    wait_idle();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
